// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath: operand widths, the adder chunk
// size and the Montgomery multiplier state encoding.
package rsa_pkg;

  localparam int unsigned N_BITS    = 512;
  localparam int unsigned ADD_W     = N_BITS + 2;
  // Bits handled per adder cycle; the adder takes ceil((ADD_W+1)/ADD_CHUNK)
  // cycles from accepting start to raising done.
  localparam int unsigned ADD_CHUNK = 128;

  // Smallest counter width w with 2^w > n.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) <= 64'(n)) w++;
    return w;
  endfunction

  localparam int unsigned CNT_BITS = cnt_width(N_BITS);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    CHK_A  = 4'd1,
    ADD_B  = 4'd2,
    WAIT_B = 4'd3,
    CHK_P  = 4'd4,
    ADD_M  = 4'd5,
    WAIT_M = 4'd6,
    SHIFT  = 4'd7,
    SUB_M  = 4'd8,
    WAIT_S = 4'd9,
    FIN    = 4'd10
  } state_t;

endpackage

// File: rtl/montgomery_bitserial_adder.sv
// Multi-precision adder/subtractor, processed CH bits per cycle.
//   clk, resetn          : clock, asynchronous active-low reset
//   start                : 1-cycle pulse, operands sampled when not busy
//   subtract             : 1 -> in_a - in_b, 0 -> in_a + in_b
//   shift                : 1 -> result is shifted right by one bit
//   in_a, in_b [W-1:0]   : operands (unsigned)
//   out_result [W:0]     : sum/difference; bit W set means negative difference
//   done                 : 1-cycle pulse, out_result valid while high
// Latency: start sampled on edge X, done rises on edge X + ceil((W+1)/CH).
module montgomery_bitserial_adder
  import rsa_pkg::*;
#(
  parameter int unsigned W  = ADD_W,
  parameter int unsigned CH = ADD_CHUNK
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         subtract,
  input  logic         shift,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic [W:0]   out_result,
  output logic         done
);

  localparam int unsigned RW  = W + 1;
  localparam int unsigned NCH = (RW + CH - 1) / CH;
  localparam int unsigned PW  = NCH * CH;
  localparam int unsigned CW  = $clog2(NCH + 1);

  logic [PW-1:0] a_sh;
  logic [PW-1:0] b_sh;
  logic [PW-1:0] sum_sh;
  logic          carry;
  logic          busy;
  logic          shift_q;
  logic [CW-1:0] cnt;
  logic [CH:0]   chunk_sum;
  logic [RW-1:0] raw;
  logic          unused_pad;

  always_comb begin
    chunk_sum = {1'b0, a_sh[CH-1:0]} + {1'b0, b_sh[CH-1:0]} + {{CH{1'b0}}, carry};
  end

  // Subtraction is a + ~b + 1 over the padded width; the low RW bits then
  // hold the two's-complement difference with bit W as the sign.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry   <= 1'b0;
      busy    <= 1'b0;
      shift_q <= 1'b0;
      cnt     <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        a_sh    <= PW'(in_a);
        b_sh    <= subtract ? ~PW'(in_b) : PW'(in_b);
        carry   <= subtract;
        shift_q <= shift;
        cnt     <= '0;
        busy    <= 1'b1;
      end else if (busy) begin
        a_sh   <= a_sh >> CH;
        b_sh   <= b_sh >> CH;
        sum_sh <= {chunk_sum[CH-1:0], sum_sh[PW-1:CH]};
        carry  <= chunk_sum[CH];
        if (cnt == CW'(NCH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign raw        = sum_sh[RW-1:0];
  assign out_result = shift_q ? {1'b0, raw[RW-1:1]} : raw;
  assign unused_pad = ^sum_sh[PW-1:RW-1];

endmodule

// File: rtl/montgomery_bitserial.sv
// Bit-serial Montgomery multiplier: result = A*B*2^-N mod M.
// Owns the accumulator, bit scanning and final reduction; every wide
// add/subtract goes through one shared adder instance.
//   clk, resetn      : clock, asynchronous active-low reset
//   start            : 1-cycle pulse, operands sampled when idle
//   in_a, in_b [N-1:0]: operands, both < M
//   in_m [N-1:0]     : modulus, odd, > 1
//   result [N-1:0]   : product, held until the next accepted start completes
//   done             : 1-cycle pulse when result is valid
module montgomery_bitserial
  import rsa_pkg::*;
#(
  parameter int unsigned N      = N_BITS,
  parameter int unsigned CNT_W  = CNT_BITS,
  parameter int unsigned ADD_CH = ADD_CHUNK
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic [N-1:0] result,
  output logic         done
);

  state_t         state;
  logic [N-1:0]   a_reg;
  logic [N-1:0]   b_reg;
  logic [N-1:0]   m_reg;
  logic [N+1:0]   c_reg;
  logic [CNT_W-1:0] idx;
  logic           add_start;
  logic           add_sub;
  logic [N+1:0]   add_in_b;
  logic [N+2:0]   add_res;
  logic           add_done;

  // Adder operands only matter in the cycle add_start is high, so the
  // B/M select and subtract flag decode straight from the state.
  always_comb begin
    add_sub  = (state == SUB_M);
    add_in_b = (state == ADD_B) ? {2'b00, b_reg} : {2'b00, m_reg};
  end

  montgomery_bitserial_adder #(
    .W  (N + 2),
    .CH (ADD_CH)
  ) u_adder (
    .clk        (clk),
    .resetn     (resetn),
    .start      (add_start),
    .subtract   (add_sub),
    .shift      (1'b0),
    .in_a       (c_reg),
    .in_b       (add_in_b),
    .out_result (add_res),
    .done       (add_done)
  );

  // add_start is raised on the transition into each ADD_*/SUB_M state so it
  // is high for exactly the one cycle spent there.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      m_reg     <= '0;
      c_reg     <= '0;
      idx       <= '0;
      add_start <= 1'b0;
      result    <= '0;
      done      <= 1'b0;
    end else begin
      done      <= 1'b0;
      add_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= in_a;
            b_reg <= in_b;
            m_reg <= in_m;
            c_reg <= '0;
            idx   <= '0;
            state <= CHK_A;
          end
        end
        CHK_A: begin
          if (a_reg[idx]) begin
            add_start <= 1'b1;
            state     <= ADD_B;
          end else begin
            state <= CHK_P;
          end
        end
        ADD_B:  state <= WAIT_B;
        WAIT_B: begin
          if (add_done) begin
            c_reg <= add_res[N+1:0];
            state <= CHK_P;
          end
        end
        CHK_P: begin
          if (c_reg[0]) begin
            add_start <= 1'b1;
            state     <= ADD_M;
          end else begin
            state <= SHIFT;
          end
        end
        ADD_M:  state <= WAIT_M;
        WAIT_M: begin
          if (add_done) begin
            c_reg <= add_res[N+1:0];
            state <= SHIFT;
          end
        end
        SHIFT: begin
          c_reg <= c_reg >> 1;
          if (idx == CNT_W'(N - 1)) begin
            add_start <= 1'b1;
            state     <= SUB_M;
          end else begin
            idx   <= idx + 1'b1;
            state <= CHK_A;
          end
        end
        SUB_M:  state <= WAIT_S;
        WAIT_S: begin
          if (add_done) begin
            // Sign bit of the difference set means C < M: keep C.
            result <= add_res[N+2] ? c_reg[N-1:0] : add_res[N-1:0];
            state  <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
